// File: rtl/sig_period_meter.sv
// Measures period and high time of a slow asynchronous square wave,
// in clk_in cycles, with one result per input period.
module sig_period_meter #(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             sig_in,
   input  logic             en,
   output logic [CNT_W-1:0] period_out,
   output logic [CNT_W-1:0] high_out,
   output logic             valid_out,
   output logic             timeout_out
);

   typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t state;
   state_t state_nxt;

   logic [SYNC_STAGES-1:0] sync;
   logic sig_s;
   logic sig_d;
   logic rise;

   logic [CNT_W-1:0] per_cnt;
   logic [CNT_W-1:0] hi_cnt;
   logic [CNT_W-1:0] per_nxt;
   logic [CNT_W-1:0] hi_nxt;
   logic [CNT_W-1:0] period_nxt;
   logic [CNT_W-1:0] high_nxt;
   logic valid_nxt;
   logic timeout_nxt;

   assign sig_s = sync[SYNC_STAGES-1];
   assign rise  = sig_s & ~sig_d;

   always_ff @(posedge clk_in) begin
      if (rst) begin
         sync  <= '0;
         sig_d <= 1'b0;
      end else begin
         sync  <= {sync[SYNC_STAGES-2:0], sig_in};
         sig_d <= sig_s;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state       <= IDLE;
         per_cnt     <= '0;
         hi_cnt      <= '0;
         period_out  <= '0;
         high_out    <= '0;
         valid_out   <= 1'b0;
         timeout_out <= 1'b0;
      end else begin
         state       <= state_nxt;
         per_cnt     <= per_nxt;
         hi_cnt      <= hi_nxt;
         period_out  <= period_nxt;
         high_out    <= high_nxt;
         valid_out   <= valid_nxt;
         timeout_out <= timeout_nxt;
      end
   end

   // Disable beats a coincident rise; a rise beats a coincident timeout.
   always_comb begin
      state_nxt   = state;
      per_nxt     = per_cnt;
      hi_nxt      = hi_cnt;
      period_nxt  = period_out;
      high_nxt    = high_out;
      valid_nxt   = 1'b0;
      timeout_nxt = 1'b0;
      unique case (state)
         IDLE: begin
            per_nxt = '0;
            hi_nxt  = '0;
            if (en) state_nxt = ARM;
         end
         ARM: begin
            if (!en) begin
               state_nxt = IDLE;
               per_nxt   = '0;
               hi_nxt    = '0;
            end else if (rise) begin
               state_nxt = MEASURE;
               per_nxt   = CNT_ONE;
               hi_nxt    = CNT_ONE;
            end
         end
         MEASURE: begin
            if (!en) begin
               state_nxt = IDLE;
               per_nxt   = '0;
               hi_nxt    = '0;
            end else if (rise) begin
               period_nxt = per_cnt;
               high_nxt   = hi_cnt;
               valid_nxt  = 1'b1;
               per_nxt    = CNT_ONE;
               hi_nxt     = CNT_ONE;
            end else if (per_cnt == CNT_MAX) begin
               state_nxt   = ARM;
               timeout_nxt = 1'b1;
               per_nxt     = '0;
               hi_nxt      = '0;
            end else begin
               per_nxt = per_cnt + CNT_ONE;
               if (sig_s) hi_nxt = hi_cnt + CNT_ONE;
            end
         end
         default: begin
            state_nxt = IDLE;
            per_nxt   = '0;
            hi_nxt    = '0;
         end
      endcase
   end

endmodule

// File: doc/sig_period_meter.md
# sig_period_meter

Measures the period and high time of a slow, asynchronous square-wave input (e.g. the `clk_out` of the team's frequency dividers) in units of `clk_in` cycles. It is the receiving end of the divider: a bench or on-chip checker feeds a divided clock in and reads back the exact cycle count per period. It is used for self-check of divider ratios and duty cycle.

## Interface
- `CNT_W`, 16: width of the period/high counters and results.
- `SYNC_STAGES`, 2: synchronizer depth for `sig_in` (≥2).

- `clk_in` input 1: system clock, all logic on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `sig_in` input 1: asynchronous signal under measurement.
- `en` input 1: measurement enable.
- `period_out` output CNT_W: last measured period, rise-to-rise, in `clk_in` cycles.
- `high_out` output CNT_W: last measured high time, in `clk_in` cycles.
- `valid_out` output 1: one-cycle pulse; new `period_out`/`high_out` are valid in this cycle.
- `timeout_out` output 1: one-cycle pulse; no rising edge seen within 2^CNT_W−1 cycles.

## Operation
- Synchronizer: a `SYNC_STAGES`-flop chain on `sig_in` produces `sig_s`. `sig_d` is `sig_s` delayed one cycle.
- `rise = sig_s & ~sig_d`.
- FSM states: IDLE, ARM, MEASURE.
  - IDLE: counters held at 0. `en=1` → ARM.
  - ARM: waits for `rise`. On `rise` → MEASURE, `per_cnt<=1`, `hi_cnt<=1`. ARM has no timeout.
  - MEASURE, `rise` cycle: `period_out<=per_cnt`, `high_out<=hi_cnt`, `valid_out<=1`, `per_cnt<=1`, `hi_cnt<=1`. Stay in MEASURE; measurement is continuous, one result per input period.
  - MEASURE, no `rise`: `per_cnt++`; `hi_cnt++` when `sig_s=1`.
  - MEASURE, `per_cnt==2^CNT_W−1` and no `rise`: `timeout_out<=1`, counters cleared, go to ARM.
  - `en=0` in ARM or MEASURE → IDLE next cycle. Counters are cleared and no result is produced.
- Result: period = number of cycles between successive rise detections. High = number of cycles with `sig_s=1` in `[rise, next rise)`.
- `hi_cnt` cannot exceed `per_cnt`, so it needs no separate saturation.
- `period_out`/`high_out` hold their last captured values through IDLE, ARM and timeout. They change only together with `valid_out`.

## Timing
- Reset values: state IDLE, synchronizer flops 0, `sig_d=0`, `per_cnt=hi_cnt=0`, `period_out=0`, `high_out=0`, `valid_out=0`, `timeout_out=0`.
- `rst` overrides everything, including mid-measurement. The first result after reset requires two fresh rising edges.
- Latency: if `sig_in` is first sampled high at clock edge k, `rise` is asserted during cycle k+SYNC_STAGES−1. The result and `valid_out` are registered at edge k+SYNC_STAGES.
- The first `valid_out` after ARM comes on the second rising edge of `sig_in`. No result is produced for the first edge.
- `valid_out` and `timeout_out` are never high in the same cycle. Both are pulses exactly one cycle long.
- Simultaneous events:
  - `rise` with `per_cnt` at maximum: `rise` wins, giving `period_out=2^CNT_W−1`, `valid_out=1`, no timeout.
  - `en` falling together with `rise`: `en` wins. No `valid_out`; go to IDLE.
- Minimum period is 2 cycles, with high and low each ≥1 cycle. Faster inputs alias; the result is unspecified, but the FSM must not lock up.

## Test plan
- Nominal: reset 10 cycles, `en=1`, `sig_in` = 4 high / 4 low (a divide-by-8 output).
  - Required: first `valid_out` SYNC_STAGES cycles after the 2nd sampled rise, with `period_out=8`, `high_out=4`.
  - Required: `valid_out` then repeats every 8 cycles with identical values.
- Duty: `sig_in` = 1 high / 9 low. Required: `period_out=10`, `high_out=1` on every result. Repeat with 9 high / 1 low and require `high_out=9`.
- Timeout: `CNT_W=4`, one rise then `sig_in=0`.
  - Required: no `valid_out`.
  - Required: `timeout_out` pulses for one cycle 16 cycles after the rise-detect cycle; state returns to ARM.
  - Required: the next two rises 6 cycles apart give `period_out=6`.
- Enable gating: drop `en` mid-period for 3 cycles, then re-raise it.
  - Required: no `valid_out` while `en=0`, and `period_out` holds its last value.
  - Required: after re-enable, the first new result appears only after two rises, with the correct value.
- Reset mid-operation: assert `rst` for 1 cycle mid-period.
  - Required: the next cycle shows all outputs 0, state IDLE.
  - Required: with `en` held high, valid results resume after two rises.
- Jitter and CDC: `sig_in` edges at random sub-cycle offsets with a nominal period of 8 cycles. Required: every `period_out` is in {7, 8, 9}, and consecutive results sum to a multiple of 8 ±1.
